// File: rtl/priority_irq_processor.sv
// Registered select/parity datapath plus edge-latched, masked,
// highest-index interrupt arbiter with a valid/ack presentation FSM.
module priority_irq_processor #(
  parameter int DATA_W  = 32,
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               data_select,
  output logic [DATA_W-1:0]  data_out,
  output logic               data_parity,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               int_en,
  output logic               irq_valid,
  output logic [IDX_W-1:0]   irq_id,
  input  logic               irq_ack,
  input  logic               ovr_clr,
  output logic [NUM_IRQ-1:0] pending,
  output logic [7:0]         status
);

  typedef enum logic {
    IDLE = 1'b0,
    ASRT = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0]  sel_data;
  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_vec;
  logic [IDX_W-1:0]   winner;
  logic               ack_fire;
  logic               ovr_set;
  logic               overrun;

  assign sel_data = data_select ? i_data : data_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      data_parity <= 1'b0;
    end else begin
      data_out    <= sel_data;
      data_parity <= ^sel_data;
    end
  end

  assign rise     = irq_req & ~req_q;
  assign eligible = pending & irq_mask;
  assign ack_fire = (state == ASRT) && irq_ack;

  always_comb begin
    ack_vec = '0;
    if (ack_fire) ack_vec[irq_id] = 1'b1;
  end

  // A re-rise on a still-pending bit loses an event unless it is being acked now
  assign ovr_set = |(rise & pending & ~ack_vec);

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) winner = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      req_q   <= irq_req;
      pending <= (pending & ~ack_vec) | rise;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == ASRT) irq_id <= winner;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (int_en && |eligible) state_nx = ASRT;
      ASRT: if (irq_ack || !int_en)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    irq_valid = 1'b0;
    unique case (state)
      ASRT:    irq_valid = 1'b1;
      default: irq_valid = 1'b0;
    endcase
  end

  assign status = {irq_valid, int_en, |pending, overrun, 4'(irq_id)};

endmodule

// File: tb/tb_priority_irq_processor.sv
// Directed and randomized bench for priority_irq_processor against
// an event-level reference model of pending/overrun/presentation.
module tb_priority_irq_processor;

  localparam int DW = 32;
  localparam int NI = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in, i_data;
  logic          data_select;
  logic [DW-1:0] data_out;
  logic          data_parity;
  logic [NI-1:0] irq_req, irq_mask;
  logic          int_en;
  logic          irq_valid;
  logic [2:0]    irq_id;
  logic          irq_ack;
  logic          ovr_clr;
  logic [NI-1:0] pending;
  logic [7:0]    status;

  int vectors = 0;
  int errors  = 0;

  logic [NI-1:0] m_prev, m_pend;
  logic          m_ovr, m_pres;
  int            m_pid;
  logic [DW-1:0] m_dout;
  logic          m_par;

  always #5 clk = ~clk;

  priority_irq_processor #(.DATA_W(DW), .NUM_IRQ(NI)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .i_data(i_data),
    .data_select(data_select),
    .data_out(data_out), .data_parity(data_parity),
    .irq_req(irq_req), .irq_mask(irq_mask),
    .int_en(int_en),
    .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_ack(irq_ack), .ovr_clr(ovr_clr),
    .pending(pending), .status(status)
  );

  task automatic check(string tag, logic [63:0] obs,
                       logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] st;
    st = {m_pres, int_en, (m_pend != 0), m_ovr, 4'(m_pid)};
    check("data_out", 64'(data_out), 64'(m_dout));
    check("parity", 64'(data_parity), 64'(m_par));
    check("irq_valid", 64'(irq_valid), 64'(m_pres));
    check("irq_id", 64'(irq_id), 64'(m_pid));
    check("pending", 64'(pending), 64'(m_pend));
    check("status", 64'(status), 64'(st));
  endtask

  // One clock: predict from pre-edge inputs, then compare after the edge
  task automatic cycle();
    logic [NI-1:0] n_pend;
    logic          n_ovr, n_pres, acked;
    int            n_pid, best;
    logic [DW-1:0] w;
    if (rst) begin
      n_pend = '0; n_ovr = 0; n_pres = 0; n_pid = 0;
      w = '0;
    end else begin
      w = data_select ? i_data : data_in;
      acked = m_pres && irq_ack;
      n_pend = m_pend;
      n_ovr = ovr_clr ? 1'b0 : m_ovr;
      for (int i = 0; i < NI; i++) begin
        if (acked && i == m_pid) n_pend[i] = 1'b0;
        if (irq_req[i] && !m_prev[i]) begin
          if (m_pend[i] && !(acked && i == m_pid)) n_ovr = 1'b1;
          n_pend[i] = 1'b1;
        end
      end
      n_pres = m_pres;
      n_pid = m_pid;
      if (m_pres) begin
        if (irq_ack || !int_en) n_pres = 1'b0;
      end else begin
        best = -1;
        for (int i = 0; i < NI; i++)
          if (m_pend[i] && irq_mask[i]) best = i;
        if (int_en && best >= 0) begin
          n_pres = 1'b1;
          n_pid = best;
        end
      end
    end
    @(posedge clk);
    #1;
    m_prev = rst ? '0 : irq_req;
    m_pend = n_pend;
    m_ovr  = n_ovr;
    m_pres = n_pres;
    m_pid  = n_pid;
    m_dout = w;
    m_par  = rst ? 1'b0 : 1'($countones(w) % 2);
    check_all();
  endtask

  task automatic wait_valid(string tag);
    int n;
    n = 0;
    while (!irq_valid && n < 8) begin
      cycle();
      n++;
    end
    check({tag, "_timeout"}, 64'(irq_valid), 64'd1);
  endtask

  initial begin
    rst = 1; data_in = '0; i_data = '0; data_select = 0;
    irq_req = 8'h01; irq_mask = 8'hFF; int_en = 0;
    irq_ack = 0; ovr_clr = 0;
    m_prev = '0; m_pend = '0; m_ovr = 0; m_pres = 0;
    m_pid = 0; m_dout = '0; m_par = 0;

    // 1) reset with a request held high
    cycle();
    cycle();
    check("rst_status", 64'(status), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    rst = 0; int_en = 1;
    cycle();
    check("t1_pending", 64'(pending), 64'h01);
    check("t1_valid0", 64'(irq_valid), 64'd0);
    cycle();
    check("t1_valid", 64'(irq_valid), 64'd1);
    check("t1_id", 64'(irq_id), 64'd0);
    irq_ack = 1;
    cycle();
    irq_ack = 0;
    check("t1_clear", 64'(pending), 64'd0);

    // 2) datapath select
    data_in = 32'hAAAA_AAAA; i_data = 32'hBBBB_BBBB;
    data_select = 0;
    cycle();
    check("t2_a", 64'(data_out), 64'hAAAA_AAAA);
    check("t2_pa", 64'(data_parity), 64'd0);
    data_select = 1;
    cycle();
    check("t2_b", 64'(data_out), 64'hBBBB_BBBB);
    check("t2_pb", 64'(data_parity), 64'd0);

    // 3) all sources rise, drained highest first
    irq_req = 8'h00;
    cycle();
    irq_req = 8'hFF;
    for (int k = 7; k >= 0; k--) begin
      wait_valid("t3_wait");
      check("t3_id", 64'(irq_id), 64'(k));
      irq_ack = 1;
      cycle();
      irq_ack = 0;
      check("t3_gap", 64'(irq_valid), 64'd0);
    end
    cycle();
    check("t3_pend0", 64'(pending), 64'd0);

    // 4) no preemption, then mask hides 7
    irq_req = 8'h00;
    cycle();
    irq_req = 8'h08;
    wait_valid("t4_wait3");
    check("t4_id3", 64'(irq_id), 64'd3);
    irq_req = 8'h88;
    cycle();
    cycle();
    check("t4_hold3", 64'(irq_id), 64'd3);
    irq_ack = 1; irq_mask = 8'h7F;
    cycle();
    irq_ack = 0;
    cycle();
    cycle();
    check("t4_masked", 64'(irq_valid), 64'd0);
    check("t4_pend7", 64'(pending[7]), 64'd1);
    irq_mask = 8'hFF;
    wait_valid("t4_wait7");
    check("t4_id7", 64'(irq_id), 64'd7);
    irq_ack = 1;
    cycle();
    irq_ack = 0;

    // 5) withdraw on int_en drop
    irq_req = 8'h00;
    cycle();
    irq_req = 8'h20;
    wait_valid("t5_wait");
    check("t5_id", 64'(irq_id), 64'd5);
    int_en = 0;
    cycle();
    check("t5_drop", 64'(irq_valid), 64'd0);
    check("t5_pend5", 64'(pending[5]), 64'd1);
    int_en = 1;
    wait_valid("t5_again");
    check("t5_id2", 64'(irq_id), 64'd5);
    irq_ack = 1;
    cycle();
    irq_ack = 0;

    // 6) overrun and rise/ack collision on bit 2
    int_en = 0;
    irq_req = 8'h00;
    cycle();
    irq_req = 8'h04;
    cycle();
    irq_req = 8'h00;
    cycle();
    irq_req = 8'h04;
    cycle();
    check("t6_ovr", 64'(status[4]), 64'd1);
    cycle();
    cycle();
    check("t6_sticky", 64'(status[4]), 64'd1);
    ovr_clr = 1;
    cycle();
    ovr_clr = 0;
    check("t6_clr", 64'(status[4]), 64'd0);
    irq_req = 8'h00;
    int_en = 1;
    wait_valid("t6_wait");
    check("t6_id", 64'(irq_id), 64'd2);
    irq_req = 8'h04; irq_ack = 1;
    cycle();
    irq_ack = 0;
    check("t6_keep", 64'(pending[2]), 64'd1);
    check("t6_noovr", 64'(status[4]), 64'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      data_in = $urandom; i_data = $urandom;
      data_select = 1'($urandom);
      irq_req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_req;
      irq_mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : irq_mask;
      int_en = ($urandom_range(0, 9) != 0);
      irq_ack = 1'($urandom);
      ovr_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
